// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port, write-first, registered-output RAM
// between requester A (CPU data bus) and requester B (display reader).
// Each access takes exactly three cycles: IDLE (arbitrate), ACCESS (RAM
// samples the command), RESP (ack pulse with read data). No pipelining.
module ram_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int RR    = 1
) (
    input  logic             clk,
    input  logic             rst,
    // port A
    input  logic             a_req,
    input  logic             a_we,
    input  logic [DEPTH-1:0] a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_ack,
    output logic [WIDTH-1:0] a_rdata,
    // port B
    input  logic             b_req,
    input  logic             b_we,
    input  logic [DEPTH-1:0] b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_ack,
    output logic [WIDTH-1:0] b_rdata,
    // RAM side
    output logic             ram_ena,
    output logic             ram_wena,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    // status
    output logic             busy,
    output logic             grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    // 0 = A, 1 = B
    logic               last_grant_q;
    logic               grant_q;

    logic               load;
    logic               pick_b;

    logic               ram_ena_q;
    logic               ram_wena_q;
    logic [DEPTH-1:0]   ram_addr_q;
    logic [WIDTH-1:0]   ram_wdata_q;

    // Read data seen by each port outside its own ack cycle
    logic [WIDTH-1:0]   a_rdata_q;
    logic [WIDTH-1:0]   b_rdata_q;

    // Next-state and arbitration decision; requests only matter in IDLE
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pick_b  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    load    = 1'b1;
                    state_d = ACCESS;
                    if (a_req && b_req) begin
                        pick_b = (RR != 0) ? ~last_grant_q : 1'b0;
                    end else begin
                        pick_b = b_req;
                    end
                end
            end
            ACCESS: state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM command registers: loaded from the winner on grant, dropped after ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ena_q    <= 1'b0;
            ram_wena_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (load) begin
            ram_ena_q    <= 1'b1;
            ram_wena_q   <= pick_b ? b_we    : a_we;
            ram_addr_q   <= pick_b ? b_addr  : a_addr;
            ram_wdata_q  <= pick_b ? b_wdata : a_wdata;
            grant_q      <= pick_b;
            last_grant_q <= pick_b;
        end else if (state_q == ACCESS) begin
            ram_ena_q    <= 1'b0;
            ram_wena_q   <= 1'b0;
        end
    end

    // Keep each port's last delivered read word once its ack cycle ends
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (state_q == RESP) begin
            if (grant_q) begin
                b_rdata_q <= ram_rdata;
            end else begin
                a_rdata_q <= ram_rdata;
            end
        end
    end

    // Output decode; RAM data is registered, so in RESP it is passed straight through
    always_comb begin
        a_ack     = (state_q == RESP) && !grant_q;
        b_ack     = (state_q == RESP) &&  grant_q;
        a_rdata   = a_ack ? ram_rdata : a_rdata_q;
        b_rdata   = b_ack ? ram_rdata : b_rdata_q;
        busy      = (state_q == ACCESS) || (state_q == RESP);
        grant     = grant_q;
        ram_ena   = ram_ena_q;
        ram_wena  = ram_wena_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance (dut) and a
// fixed-priority instance (dut_fp), each attached to its own behavioural
// write-first RAM with registered output.
module tb_ram_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- round-robin instance ----------------
    logic             a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [DEPTH-1:0] a_addr = '0, b_addr = '0;
    logic [WIDTH-1:0] a_wdata = '0, b_wdata = '0;
    logic             a_ack, b_ack, ram_ena, ram_wena, busy, grant;
    logic [WIDTH-1:0] a_rdata, b_rdata, ram_wdata;
    logic [WIDTH-1:0] ram_rdata = '0;
    logic [DEPTH-1:0] ram_addr;
    logic [WIDTH-1:0] mem [2**DEPTH];

    ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RR(1)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .grant(grant)
    );

    // ---------------- fixed-priority instance ----------------
    logic             f_a_req = 0, f_b_req = 0;
    logic             f_a_ack, f_b_ack, f_ram_ena, f_ram_wena, f_busy, f_grant;
    logic [WIDTH-1:0] f_a_rdata, f_b_rdata, f_ram_wdata;
    logic [WIDTH-1:0] f_ram_rdata = '0;
    logic [DEPTH-1:0] f_ram_addr;
    logic [WIDTH-1:0] f_mem [2**DEPTH];

    ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .a_req(f_a_req), .a_we(1'b0), .a_addr(3'd2), .a_wdata(8'h00),
        .a_ack(f_a_ack), .a_rdata(f_a_rdata),
        .b_req(f_b_req), .b_we(1'b0), .b_addr(3'd5), .b_wdata(8'h00),
        .b_ack(f_b_ack), .b_rdata(f_b_rdata),
        .ram_ena(f_ram_ena), .ram_wena(f_ram_wena), .ram_addr(f_ram_addr),
        .ram_wdata(f_ram_wdata), .ram_rdata(f_ram_rdata),
        .busy(f_busy), .grant(f_grant)
    );

    initial begin
        for (int i = 0; i < 2**DEPTH; i++) begin
            mem[i]   = '0;
            f_mem[i] = WIDTH'(8'h10 + i);
        end
    end

    // Behavioural RAMs: write-first, registered data_out
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wena) begin
                mem[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata     <= mem[ram_addr];
            end
        end
        if (f_ram_ena) begin
            if (f_ram_wena) begin
                f_mem[f_ram_addr] <= f_ram_wdata;
                f_ram_rdata       <= f_ram_wdata;
            end else begin
                f_ram_rdata       <= f_mem[f_ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int a_cnt, b_cnt;

    initial begin
        tick();
        tick();
        // reset values
        check("rst_ram_ena", ram_ena, 0);
        check("rst_ram_wena", ram_wena, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_acks", {a_ack, b_ack}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_busy_grant", {busy, grant}, 0);
        rst = 0;
        tick();

        // Test 1: A writes 0x5A to addr 3
        a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h5A;
        tick();
        check("t1_access_ena_wena", {ram_ena, ram_wena}, 2'b11);
        check("t1_access_addr", ram_addr, 3);
        check("t1_access_wdata", ram_wdata, 8'h5A);
        check("t1_access_busy_ack", {busy, a_ack, b_ack}, 3'b100);
        tick();
        check("t1_resp_acks", {a_ack, b_ack}, 2'b10);
        check("t1_resp_rdata", a_rdata, 8'h5A);
        check("t1_resp_ena", {ram_ena, ram_wena}, 0);
        tick();
        a_req = 0; a_we = 0;
        check("t1_idle", {busy, a_ack}, 0);
        tick();
        check("t1_no_reserve", {busy, a_ack, ram_ena}, 0);

        // Test 2: B reads addr 3
        b_req = 1; b_we = 0; b_addr = 3;
        tick();
        check("t2_access", {ram_ena, ram_wena, grant}, 3'b101);
        tick();
        check("t2_resp_acks", {a_ack, b_ack, ram_wena}, 3'b010);
        check("t2_resp_rdata", b_rdata, 8'h5A);
        tick();
        b_req = 0;
        check("t2_rdata_hold", {a_rdata, b_rdata}, 16'h5A5A);

        // Test 3: round robin, both held for 4 accesses (A reads 3, B reads 0)
        a_req = 1; a_we = 0; a_addr = 3;
        b_req = 1; b_we = 0; b_addr = 0;
        a_cnt = 0; b_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_grant%0d", i), grant, i % 2);
            if (a_ack) a_cnt++;
            if (b_ack) b_cnt++;
            tick();
            check($sformatf("t3_ack%0d", i), {a_ack, b_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
            check($sformatf("t3_rdata%0d", i), (i % 2 == 0) ? a_rdata : b_rdata,
                  (i % 2 == 0) ? 8'h5A : 8'h00);
            if (a_ack) a_cnt++;
            if (b_ack) b_cnt++;
            tick();
            if (a_ack) a_cnt++;
            if (b_ack) b_cnt++;
        end
        a_req = 0; b_req = 0;
        check("t3_a_count", a_cnt, 2);
        check("t3_b_count", b_cnt, 2);

        // Test 6: A read request dropped one cycle after grant
        tick();
        a_req = 1; a_addr = 3;
        a_cnt = 0;
        tick();
        check("t6_granted", {busy, grant}, 2'b10);
        a_req = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_ack) a_cnt++;
        end
        check("t6_ack_once", a_cnt, 1);
        check("t6_idle", {busy, ram_ena}, 0);

        // Test 5: reset during ACCESS of A write 0x77 to addr 1
        a_req = 1; a_we = 1; a_addr = 1; a_wdata = 8'h77;
        tick();
        check("t5_access", {ram_ena, ram_wena, ram_addr}, {2'b11, 3'd1});
        rst = 1;
        tick();
        rst = 0; a_req = 0; a_we = 0;
        check("t5_rst_ack", {a_ack, b_ack}, 0);
        check("t5_rst_ram", {ram_ena, ram_wena, ram_addr, ram_wdata}, 0);
        check("t5_rst_busy_grant", {busy, grant}, 0);
        tick();
        check("t5_no_late_ack", {a_ack, busy}, 0);
        b_req = 1; b_we = 0; b_addr = 1;
        tick();
        tick();
        check("t5_b_ack", b_ack, 1);
        check("t5_b_rdata", b_rdata, 8'h77);
        tick();
        b_req = 0;

        // Test 4: fixed priority, both held (A reads addr 2 = 0x12, B reads addr 5 = 0x15)
        f_a_req = 1; f_b_req = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("t4_grant%0d", i), f_grant, 0);
            tick();
            check($sformatf("t4_ack%0d", i), {f_a_ack, f_b_ack}, 2'b10);
            check($sformatf("t4_rdata%0d", i), f_a_rdata, 8'h12);
            tick();
        end
        f_a_req = 0;
        tick();
        check("t4_b_grant", f_grant, 1);
        tick();
        check("t4_b_ack", {f_a_ack, f_b_ack}, 2'b01);
        check("t4_b_rdata", f_b_rdata, 8'h15);
        f_b_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
